// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 4-digit HH:MM 7-segment scan with anti-ghost blanking, blink and leading-zero suppression.
module seg7_enc (
  input  logic [3:0] d,
  output logic [6:0] seg
);
  always_comb begin
    case (d)
      4'd0: seg = 7'b0111111;
      4'd1: seg = 7'b0000110;
      4'd2: seg = 7'b1011011;
      4'd3: seg = 7'b1001111;
      4'd4: seg = 7'b1100110;
      4'd5: seg = 7'b1101101;
      4'd6: seg = 7'b1111101;
      4'd7: seg = 7'b0000111;
      4'd8: seg = 7'b1111111;
      4'd9: seg = 7'b1100111;
      default: seg = 7'b1111001;
    endcase
  end
endmodule

module display_scan_ctrl #(
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 125
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic [3:0]  blink_mask,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [1:0]  digit_idx,
  output logic        frame_done
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  logic [15:0]   shadow;
  logic [3:0]    smask;
  logic          wrap, fb, hidden;
  logic [3:0]    cur;
  logic [6:0]    eseg;
  assign wrap = cnt == CW'(CLK_DIV - 1);
  assign fb = wrap && idx == 2'd3;
  assign cur = shadow[{idx, 2'b00} +: 4];
  // lz_en is deliberately live so the setting takes effect without waiting a frame
  assign hidden = (cnt < CW'(BLANK_CYCLES)) | (smask[idx] & ~blink_phase)
                | (idx == 2'd3 & lz_en & shadow[15:12] == 4'd0);
  seg7_enc u_enc (.d(cur), .seg(eseg));
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b1;
      shadow <= '0;
      smask <= '0;
      an <= 4'b1111;
      seg <= '0;
      digit_idx <= '0;
      frame_done <= 1'b0;
    end else begin
      cnt <= wrap ? '0 : cnt + 1'b1;
      if (wrap) idx <= idx + 1'b1;
      if (fb) begin
        shadow <= digits_in;
        smask <= blink_mask;
        blink_cnt <= (blink_cnt == BW'(BLINK_FRAMES - 1)) ? '0 : blink_cnt + 1'b1;
        if (blink_cnt == BW'(BLINK_FRAMES - 1)) blink_phase <= ~blink_phase;
      end
      an <= hidden ? 4'b1111 : ~(4'b0001 << idx);
      seg <= hidden ? 7'h00 : eseg;
      digit_idx <= idx;
      frame_done <= fb;
    end
  end
endmodule
